// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: reset PC, the bubble
// instruction and the fetch FSM state type.
package if_pkg;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH,
      HOLD,
      DROP
   } if_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: 32-bit instruction plus 32-bit PC. A bubble
// overrides a load; with neither asserted the register keeps its contents.
module if_id_reg
   import if_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        bubble,
   input  logic [31:0] insn_in,
   input  logic [31:0] pc_in,
   output logic [31:0] insn_out,
   output logic [31:0] pc_out
);

   logic [31:0] insn_d, insn_q;
   logic [31:0] pc_d, pc_q;

   // Next-value selection: a bubble beats a load, otherwise hold.
   always_comb begin
      insn_d = insn_q;
      pc_d   = pc_q;
      if (bubble) begin
         insn_d = NOP_INSN;
         pc_d   = 32'h0000_0000;
      end else if (load) begin
         insn_d = insn_in;
         pc_d   = pc_in;
      end
   end

   // Register update; reset leaves a NOP with PC 0 in the pipeline.
   always_ff @(posedge clk) begin
      if (reset) begin
         insn_q <= NOP_INSN;
         pc_q   <= 32'h0000_0000;
      end else begin
         insn_q <= insn_d;
         pc_q   <= pc_d;
      end
   end

   assign insn_out = insn_q;
   assign pc_out   = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage. Owns the PC, talks to instruction memory over a
// req/ack handshake, buffers a fetch that lands during an ID stall and
// retires an in-flight request before following a redirect.
module if_stage
   import if_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        IFWrite,
   input  logic        Branch,
   input  logic        Jump,
   input  logic [31:0] JumpAddr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Instruction_id,
   output logic [31:0] PC_id
);

   if_state_t   state_d, state_q;
   logic [31:0] pc_d, pc_q;
   logic [31:0] buf_insn_d, buf_insn_q;
   logic [31:0] buf_pc_d, buf_pc_q;
   logic [31:0] target_d, target_q;

   logic        redirect;
   logic [31:0] target;
   logic        reg_load;
   logic        reg_bubble;
   logic [31:0] reg_insn;
   logic [31:0] reg_pc;

   // A stall always wins over a redirect; targets are forced halfword aligned.
   assign redirect = (Branch | Jump) & IFWrite;
   assign target   = JumpAddr & 32'hFFFF_FFFE;

   // The request address is the PC itself, so it cannot move until pc_q does.
   assign imem_req  = ~reset & (state_q != HOLD);
   assign imem_addr = pc_q;

   // Fetch FSM: decides the next PC, buffer contents and IF/ID update.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      buf_insn_d = buf_insn_q;
      buf_pc_d   = buf_pc_q;
      target_d   = target_q;
      reg_load   = 1'b0;
      reg_bubble = 1'b0;
      reg_insn   = imem_rdata;
      reg_pc     = pc_q;
      unique case (state_q)
         FETCH: begin
            if (redirect) begin
               reg_bubble = 1'b1;
               if (imem_ack) begin
                  pc_d = target;
               end else begin
                  target_d = target;
                  state_d  = DROP;
               end
            end else if (imem_ack) begin
               pc_d = pc_q + 32'd4;
               if (IFWrite) begin
                  reg_load = 1'b1;
               end else begin
                  buf_insn_d = imem_rdata;
                  buf_pc_d   = pc_q;
                  state_d    = HOLD;
               end
            end else if (IFWrite) begin
               reg_bubble = 1'b1;
            end
         end
         HOLD: begin
            if (IFWrite) begin
               state_d = FETCH;
               if (redirect) begin
                  reg_bubble = 1'b1;
                  pc_d       = target;
               end else begin
                  reg_load = 1'b1;
                  reg_insn = buf_insn_q;
                  reg_pc   = buf_pc_q;
               end
            end
         end
         DROP: begin
            reg_bubble = IFWrite;
            if (redirect) begin
               target_d = target;
            end
            if (imem_ack) begin
               pc_d    = redirect ? target : target_q;
               state_d = FETCH;
            end
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   // State, PC, stall buffer and pending redirect target.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         buf_insn_q <= NOP_INSN;
         buf_pc_q   <= 32'h0000_0000;
         target_q   <= RESET_PC;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         buf_insn_q <= buf_insn_d;
         buf_pc_q   <= buf_pc_d;
         target_q   <= target_d;
      end
   end

   if_id_reg u_if_id_reg (
      .clk      (clk),
      .reset    (reset),
      .load     (reg_load),
      .bubble   (reg_bubble),
      .insn_in  (reg_insn),
      .pc_in    (reg_pc),
      .insn_out (Instruction_id),
      .pc_out   (PC_id)
   );

endmodule
